// File: rtl/alioth_issue_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package alioth_issue_pkg;

    localparam int unsigned REG_ADDR_WIDTH          = 5;
    localparam int unsigned NUM_REGS                = 32;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 4;

    // Bit positions inside hazard_o
    localparam int unsigned HAZ_RAW    = 0;
    localparam int unsigned HAZ_WAW    = 1;
    localparam int unsigned HAZ_STRUCT = 2;

    typedef enum logic [0:0] {
        ISSUE_RUN,
        ISSUE_DRAIN
    } issue_state_e;

    // One-hot decode of a register address, gated by an enable
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic                      en,
                                                       input logic [REG_ADDR_WIDTH-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        if (en) begin
            oh[addr] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard and in-flight long-op counter. Read ports
// return the effective pending state, i.e. with this cycle's writeback
// already cleared so a dependent instruction can use the regfile bypass.
module issue_scoreboard
    import alioth_issue_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // Set port: long op with a destination issues this cycle
    input  logic                      set_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    // Counter increment: any long op issues this cycle
    input  logic                      inc_i,
    // Writeback of a long op
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr_i,
    // Read ports
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      rs1_pend_o,
    output logic                      rs2_pend_o,
    output logic                      rd_pend_o,
    output logic [CNT_W-1:0]          cnt_o,
    output logic [CNT_W-1:0]          cnt_eff_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] clr_mask, set_mask, pend_eff;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cnt_dec_ok;

    // Scoreboard next state: clear on writeback, then set on issue (set wins)
    always_comb begin
        clr_mask     = reg_onehot(wb_valid_i, wb_waddr_i);
        set_mask     = reg_onehot(set_en_i, set_addr_i);
        pend_eff     = pending_q & ~clr_mask;
        pending_d    = pend_eff | set_mask;
        // x0 is hardwired zero and can never be pending
        pending_d[0] = 1'b0;
    end

    // Counter next state; a writeback against an empty counter saturates at 0
    always_comb begin
        cnt_dec_ok = wb_valid_i & (cnt_q != '0);
        cnt_eff_o  = cnt_q - CNT_W'(cnt_dec_ok);
        if (wb_valid_i && !inc_i && (cnt_q == '0)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(inc_i) - CNT_W'(wb_valid_i);
        end
    end

    // Read ports see the writeback-cleared view
    always_comb begin
        rs1_pend_o = pend_eff[rs1_addr_i];
        rs2_pend_o = pend_eff[rs2_addr_i];
        rd_pend_o  = pend_eff[rd_addr_i];
        cnt_o      = cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue controller: RAW/WAW/structural hazard detection against
// the long-op scoreboard, plus a drain FSM that holds serializing
// instructions (CSR writes, fences) until nothing is in flight.
module idu_issue_ctrl
    import alioth_issue_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int unsigned CNT_W           = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid_i,
    input  logic                      rs1_used_i,
    input  logic                      rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg2_raddr_i,
    input  logic                      reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                      is_long_i,
    input  logic                      is_serial_i,
    input  logic                      ex_ready_i,
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic                      flush_i,
    output logic                      issue_o,
    output logic                      stall_o,
    output logic [2:0]                hazard_o,
    output logic [CNT_W-1:0]          outstanding_o
);

    issue_state_e     state_q, state_d;

    logic             rs1_pend, rs2_pend, rd_pend;
    logic [CNT_W-1:0] cnt_eff;
    logic             cnt_nz;
    logic             raw, waw, structural, drain_block;
    logic             sb_set_en, sb_inc;

    issue_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set_en),
        .set_addr_i (reg_waddr_i),
        .inc_i      (sb_inc),
        .wb_valid_i (wb_valid_i),
        .wb_waddr_i (wb_waddr_i),
        .rs1_addr_i (reg1_raddr_i),
        .rs2_addr_i (reg2_raddr_i),
        .rd_addr_i  (reg_waddr_i),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .rd_pend_o  (rd_pend),
        .cnt_o      (outstanding_o),
        .cnt_eff_o  (cnt_eff)
    );

    // Drain FSM: next state and the drain blocking term
    always_comb begin
        state_d     = state_q;
        drain_block = 1'b0;
        cnt_nz      = (cnt_eff != '0);
        case (state_q)
            ISSUE_RUN: begin
                drain_block = is_serial_i & cnt_nz;
                if (dec_valid_i && !flush_i && is_serial_i && cnt_nz) begin
                    state_d = ISSUE_DRAIN;
                end
            end
            ISSUE_DRAIN: begin
                // Held serial instruction may go once the last writeback lands
                drain_block = cnt_nz;
                if (flush_i || !cnt_nz) begin
                    state_d = ISSUE_RUN;
                end
            end
            default: begin
                state_d = ISSUE_RUN;
            end
        endcase
    end

    // Hazard detection, issue/stall decision and scoreboard update requests
    always_comb begin
        raw        = (rs1_used_i & rs1_pend) | (rs2_used_i & rs2_pend);
        waw        = reg_we_i & rd_pend;
        // A same-cycle writeback frees a slot, so full-but-retiring still issues
        structural = is_long_i & (cnt_eff == CNT_W'(MAX_OUTSTANDING));

        issue_o = dec_valid_i & ~flush_i & ex_ready_i & ~raw & ~waw & ~structural
                  & ~drain_block;
        stall_o = dec_valid_i & ~flush_i & ~issue_o;

        hazard_o = '0;
        if (stall_o) begin
            hazard_o[HAZ_RAW]    = raw;
            hazard_o[HAZ_WAW]    = waw;
            hazard_o[HAZ_STRUCT] = structural | drain_block;
        end

        sb_inc    = issue_o & is_long_i;
        sb_set_en = sb_inc & reg_we_i & (reg_waddr_i != '0);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/idu_issue_ctrl.md
# idu_issue_ctrl

Scoreboard-based issue controller for the decode stage. It watches the instruction currently held in the decode stage, tracks destination registers of in-flight long-latency ops (loads, mul/div), and decides each cycle whether that instruction may issue or must stall. It also serializes CSR-writing and fence instructions by draining all outstanding ops first. Its stall output feeds the pipeline control unit, which drives the `stall_flag_i` bus of the decode unit.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum in-flight long-latency ops; range 1..15.
- `CNT_W`, default 4: width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dec_valid_i`  in  1  decode stage holds a valid instruction.
- `rs1_used_i`, `rs2_used_i`  in  1 each  source operand read enables.
- `reg1_raddr_i`, `reg2_raddr_i`  in  `REG_ADDR_WIDTH` each  source register addresses.
- `reg_we_i`  in  1  instruction writes a GPR.
- `reg_waddr_i`  in  `REG_ADDR_WIDTH`  destination register.
- `is_long_i`  in  1  instruction is long-latency (load/mul/div).
- `is_serial_i`  in  1  CSR write or fence; requires an empty pipeline.
- `ex_ready_i`  in  1  execute stage can accept an instruction this cycle.
- `wb_valid_i`  in  1  a long-latency op writes back this cycle.
- `wb_waddr_i`  in  `REG_ADDR_WIDTH`  its destination.
- `flush_i`  in  1  kill the instruction currently in decode (branch mispredict/trap).
- `issue_o`  out  1  instruction issues this cycle (combinational).
- `stall_o`  out  1  hold the fetch/decode registers (combinational).
- `hazard_o`  out  3  cause: [0] RAW, [1] WAW, [2] structural/drain.
- `outstanding_o`  out  `CNT_W`  registered count of in-flight long ops.

## Operation
- Scoreboard: `pending[31:1]` registered bits; x0 is never pending and never creates a hazard.
- Effective pending `eff = pending & ~clr`, where `clr` is the one-hot of `wb_waddr_i` when `wb_valid_i`. The regfile write-through bypass allows a dependent instruction to issue in the writeback cycle.
- RAW: `(rs1_used_i & eff[reg1_raddr_i]) | (rs2_used_i & eff[reg2_raddr_i])`.
- WAW: `reg_we_i & eff[reg_waddr_i]`.
- Structural: `is_long_i & (cnt_eff == MAX_OUTSTANDING)`, where `cnt_eff = outstanding - wb_valid_i`.
- FSM, states RUN and DRAIN:
  - In RUN, a valid `is_serial_i` instruction with `cnt_eff != 0` enters DRAIN and stalls.
  - In DRAIN, the controller stalls until `cnt_eff == 0`, then returns to RUN in the same cycle the serial instruction issues.
  - Drain sets `hazard_o[2]`.
- `issue_o = dec_valid_i & ~flush_i & ex_ready_i & ~RAW & ~WAW & ~struct & ~drain_block`.
- `stall_o = dec_valid_i & ~flush_i & ~issue_o`.
- `hazard_o` reports every active cause; it is 0 whenever `stall_o` is 0.
- On issue of a long op with `reg_we_i` and a nonzero destination, set `pending[reg_waddr_i]`. On a long op without a writeback register, only the counter is incremented.
- Counter: `next = outstanding + (issue_o & is_long_i) - wb_valid_i`.
- `flush_i` does not clear the scoreboard: in-flight ops still write back. While flush is high, FSM DRAIN returns to RUN.
- Illegal `wb_valid_i` with `outstanding == 0`: the counter saturates at 0 and the bench flags it as an assertion.

## Timing
- Reset, the cycle after `rst` is sampled high: `pending = 0`, `outstanding_o = 0`, FSM in RUN. `issue_o`, `stall_o` and `hazard_o` are then 0 unless `dec_valid_i` is high.
- `issue_o`, `stall_o` and `hazard_o` are combinational from inputs and registered state: zero latency. Scoreboard and counter update at the next rising edge.
- Simultaneous set and clear of the same register in one cycle: set wins, so the bit stays 1.
- Simultaneous issue of a long op and a writeback: the counter is unchanged. That issue is permitted even when `outstanding == MAX_OUTSTANDING`.
- `rst` mid-operation discards all pending state; late writebacks after reset are ignored, and the counter saturates at 0.

## Structure
- Shared package `alioth_issue_pkg`: FSM state enum (`ISSUE_RUN`, `ISSUE_DRAIN`), hazard bit index constants, and the `MAX_OUTSTANDING` default.
- One sub-module, `issue_scoreboard`, holding the pending bits, the counter and the set/clear logic, with read ports for rs1, rs2 and rd. The FSM and issue logic live in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles with `dec_valid_i = 1` and a non-long instruction -> `issue_o = 1`, `outstanding_o = 0`.
- RAW: load to x5 issues; next instruction reads x5 -> `stall_o = 1`, `hazard_o = 3'b001` until `wb_valid_i` with `wb_waddr_i = 5`, then `issue_o = 1` in that same cycle.
- WAW plus same-cycle set/clear: pending x7; writeback of x7 coincides with issue of a new load to x7 -> issue allowed, `pending[7]` remains 1, `outstanding_o` unchanged.
- Structural: issue 4 long ops with no writeback -> `outstanding_o = 4`; a 5th long op stalls with `hazard_o[2] = 1`; one writeback -> the 5th issues the same cycle.
- Drain: 2 ops outstanding, then a CSR write arrives -> FSM in DRAIN, stall for 2 writebacks, issue on the cycle `cnt_eff` reaches 0, FSM returns to RUN.
- Flush: a stalled RAW instruction with `flush_i = 1` -> `issue_o = 0`, `stall_o = 0`, `pending` unchanged.
